affine_pe_stream: RTL and testbench
===================================

# affine_pe_stream

Parametrised affine-gap scoring processing element for the linear systolic alignment array. Holds one query base, consumes one reference column per valid beat from its upstream neighbour, computes H/E/F with saturating signed arithmetic in local or global mode, and forwards registered results plus a 4-bit traceback pointer downstream. It supersedes the fixed 33-bit PE with valid-qualified streaming, configurable widths, a global mode, saturation and optional max-score tracking.

## Interface
- SCORE_W, 16, signed score width; NEG_INF = -2^(SCORE_W-1), POS_MAX = 2^(SCORE_W-1)-1
- BASE_W, 3, base code width
- COL_W, 12, column counter width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- cfg_match  in  SCORE_W  signed score added on q_base == in_r
- cfg_mismatch  in  SCORE_W  signed score added on mismatch
- cfg_gap_o  in  SCORE_W  unsigned gap-open penalty
- cfg_gap_e  in  SCORE_W  unsigned gap-extend penalty
- cfg_local  in  1  1 = local (H floor 0), 0 = global
- q_load  in  1  starts a new row: latch q_base_in, init_h, init_diag
- q_base_in  in  BASE_W  query base for this row
- init_h  in  SCORE_W  H(i,0), left boundary of this row
- init_diag  in  SCORE_W  H(i-1,0), diagonal for the first column
- in_valid  in  1  upstream beat valid
- in_r  in  BASE_W  reference base
- in_h  in  SCORE_W  H(i-1,j) from upstream PE
- in_f  in  SCORE_W  F(i-1,j) from upstream PE
- out_valid, out_r, out_h, out_f  out  1/BASE_W/SCORE_W/SCORE_W  registered beat to downstream PE
- out_ptr  out  4  traceback pointer of out_h
- max_h  out  SCORE_W  best H this row
- max_col  out  COL_W  column (1-based) of max_h

## Operation
- Internal state: q_base, h_left (H(i,j-1)), e_left (E(i,j-1)), h_diag, col.
- q_load: q_base<=q_base_in, h_left<=init_h, e_left<=NEG_INF, h_diag<=init_diag, col<=0, max cleared. q_load wins over a simultaneous in_valid; that beat is dropped (out_valid=0).
- Per valid beat, with s = match/mismatch:
  - E = max(h_left - gap_o, e_left - gap_e); F = max(in_h - gap_o, in_f - gap_e); D = h_diag + s.
  - H = max(D, F, E, and 0 if cfg_local). Ties: D > F > E > 0.
  - Then h_left<=H, e_left<=E, h_diag<=in_h, col<=col+1 (saturates at all-ones).
- All arithmetic in SCORE_W+2 bits, result clamped to [NEG_INF, POS_MAX]; NEG_INF minus any penalty stays NEG_INF.
- out_ptr: [1:0] H source 0=zero,1=E,2=F,3=diag; [2]=1 if E from extension; [3]=1 if F from extension (extension wins ties = 0 on equality, i.e. open preferred).
- in_valid low: no state change, out_valid<=0, other outputs hold.

## Timing
- Latency 1 cycle: beat at edge k appears on out_* after edge k; full throughput, one beat/cycle.
- Reset: every output 0, out_valid 0; e_left=NEG_INF, h_left=h_diag=0, q_base=0, col=0, max_h=NEG_INF internally (max_h output 0 until first valid beat).
- Reset mid-row aborts the row; first beat after release without q_load uses reset state.

## Configuration
- PE_MAX_TRACK_EN defined: max_h/max_col register the first strictly-greater H of the row and its col; cleared on q_load.
- Undefined: tracking logic absent, max_h and max_col tied to 0.

## Test plan
Default cfg: match +2, mismatch -1, gap_o 3, gap_e 1, SCORE_W 16.
- Local, q_load q=A, beats r=A,C,A, in_h=0, in_f=NEG_INF -> out_h 2,0,2; out_ptr[1:0] 3,0,3.
- Global, q_load init_h=-3, init_diag=0, q=A, beat r=C, in_h=0 -> out_h -1, ptr[1:0]=3; E=-6, F=-3.
- Saturation: in_h=h_diag=32767 match -> out_h 32767; in_f=-32768 -> F not below -32768, no wrap.
- Bubbles: in_valid 1,0,1 vs 1,1 -> identical out_h sequence, out_valid gaps mirrored 1 cycle later.
- PE_MAX_TRACK_EN: H sequence 2,0,2,4,4 -> max_h 4, max_col 4; next q_load clears.
- q_load with in_valid same cycle -> no out_valid; rst during stream -> outputs 0 asynchronously.

Source files
------------

// File: rtl/affine_pe_stream_if.sv
// rtl/affine_pe_stream_if.sv - column beat between neighbouring PEs of the systolic alignment array.
interface affine_pe_stream_if #(
  parameter int SCORE_W = 16,
  parameter int BASE_W  = 3
);
  logic                      valid;
  logic [BASE_W-1:0]         r;
  logic signed [SCORE_W-1:0] h;
  logic signed [SCORE_W-1:0] f;

  modport master (output valid, r, h, f);
  modport slave  (input  valid, r, h, f);
endinterface

// File: rtl/affine_pe_stream.sv
// rtl/affine_pe_stream.sv - affine-gap scoring PE with saturating H/E/F and a traceback pointer.
// Define PE_MAX_TRACK_EN to register the best H of the row and its 1-based column.
module affine_pe_stream #(
  parameter int SCORE_W = 16,
  parameter int BASE_W  = 3,
  parameter int COL_W   = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [SCORE_W-1:0] cfg_match,
  input  logic signed [SCORE_W-1:0] cfg_mismatch,
  input  logic [SCORE_W-1:0]        cfg_gap_o,
  input  logic [SCORE_W-1:0]        cfg_gap_e,
  input  logic                      cfg_local,
  input  logic                      q_load,
  input  logic [BASE_W-1:0]         q_base_in,
  input  logic signed [SCORE_W-1:0] init_h,
  input  logic signed [SCORE_W-1:0] init_diag,
  affine_pe_stream_if.slave         in_s,
  affine_pe_stream_if.master        out_s,
  output logic [3:0]                out_ptr,
  output logic signed [SCORE_W-1:0] max_h,
  output logic [COL_W-1:0]          max_col
);
  localparam int W2 = SCORE_W + 2;
  localparam logic signed [SCORE_W-1:0] NEG_INF = {1'b1, {(SCORE_W-1){1'b0}}};
  localparam logic signed [SCORE_W-1:0] POS_MAX = {1'b0, {(SCORE_W-1){1'b1}}};

  function automatic logic signed [W2-1:0] sx(input logic signed [SCORE_W-1:0] v);
    sx = {{2{v[SCORE_W-1]}}, v};
  endfunction

  function automatic logic signed [W2-1:0] zx(input logic [SCORE_W-1:0] v);
    zx = {2'b00, v};
  endfunction

  // Clamping also keeps NEG_INF pinned when a penalty is subtracted from it.
  function automatic logic signed [SCORE_W-1:0] sat(input logic signed [W2-1:0] x);
    if (x > sx(POS_MAX))      sat = POS_MAX;
    else if (x < sx(NEG_INF)) sat = NEG_INF;
    else                      sat = x[SCORE_W-1:0];
  endfunction

  logic [BASE_W-1:0]         q_base;
  logic signed [SCORE_W-1:0] h_left, e_left, h_diag;

  logic signed [SCORE_W-1:0] s_val, e_open, e_ext, f_open, f_ext;
  logic signed [SCORE_W-1:0] d_val, e_val, f_val, h_val;
  logic                      e_from_ext, f_from_ext;
  logic [1:0]                h_src;

  always_comb begin
    s_val      = (q_base == in_s.r) ? cfg_match : cfg_mismatch;
    e_open     = sat(sx(h_left) - zx(cfg_gap_o));
    e_ext      = sat(sx(e_left) - zx(cfg_gap_e));
    f_open     = sat(sx(in_s.h) - zx(cfg_gap_o));
    f_ext      = sat(sx(in_s.f) - zx(cfg_gap_e));
    e_from_ext = e_ext > e_open;
    f_from_ext = f_ext > f_open;
    e_val      = e_from_ext ? e_ext : e_open;
    f_val      = f_from_ext ? f_ext : f_open;
    d_val      = sat(sx(h_diag) + sx(s_val));
    h_src      = 2'd0;
    h_val      = '0;
    // Tie order D > F > E > 0; the zero floor only competes in local mode.
    if (d_val >= f_val && d_val >= e_val && (!cfg_local || !d_val[SCORE_W-1])) begin
      h_src = 2'd3;
      h_val = d_val;
    end else if (f_val >= e_val && (!cfg_local || !f_val[SCORE_W-1])) begin
      h_src = 2'd2;
      h_val = f_val;
    end else if (!cfg_local || !e_val[SCORE_W-1]) begin
      h_src = 2'd1;
      h_val = e_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_base      <= '0;
      h_left      <= '0;
      e_left      <= NEG_INF;
      h_diag      <= '0;
      out_s.valid <= 1'b0;
      out_s.r     <= '0;
      out_s.h     <= '0;
      out_s.f     <= '0;
      out_ptr     <= '0;
    end else if (q_load) begin
      q_base      <= q_base_in;
      h_left      <= init_h;
      e_left      <= NEG_INF;
      h_diag      <= init_diag;
      out_s.valid <= 1'b0;
    end else if (in_s.valid) begin
      h_left      <= h_val;
      e_left      <= e_val;
      h_diag      <= in_s.h;
      out_s.valid <= 1'b1;
      out_s.r     <= in_s.r;
      out_s.h     <= h_val;
      out_s.f     <= f_val;
      out_ptr     <= {f_from_ext, e_from_ext, h_src};
    end else begin
      out_s.valid <= 1'b0;
    end
  end

`ifdef PE_MAX_TRACK_EN
  logic [COL_W-1:0]          col, col_next, max_col_q;
  logic signed [SCORE_W-1:0] max_q;
  logic                      max_seen;

  assign col_next = (&col) ? col : col + COL_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      max_q     <= NEG_INF;
      max_col_q <= '0;
      max_seen  <= 1'b0;
    end else if (q_load) begin
      col       <= '0;
      max_q     <= NEG_INF;
      max_col_q <= '0;
      max_seen  <= 1'b0;
    end else if (in_s.valid) begin
      col      <= col_next;
      max_seen <= 1'b1;
      if (h_val > max_q) begin
        max_q     <= h_val;
        max_col_q <= col_next;
      end
    end
  end

  // The internal NEG_INF floor is hidden until the row has produced a beat.
  assign max_h   = max_seen ? max_q : '0;
  assign max_col = max_col_q;
`else
  assign max_h   = '0;
  assign max_col = '0;
`endif
endmodule

// File: tb/tb_affine_pe_stream.sv
// tb/tb_affine_pe_stream.sv - directed vector bench for affine_pe_stream.
// Define PE_MAX_TRACK_EN here too when the DUT is built with max tracking.
module tb_affine_pe_stream;
  localparam logic signed [15:0] NI = 16'sh8000;

  typedef struct {
    logic              loc;
    logic              ql;
    logic [2:0]        qb;
    logic signed [15:0] ih;
    logic signed [15:0] id;
    logic              v;
    logic [2:0]        r;
    logic signed [15:0] h;
    logic signed [15:0] f;
    logic              ev;
    logic signed [15:0] eh;
    logic signed [15:0] ef;
    logic [3:0]        ep;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [15:0] cfg_match = 16'sd2;
  logic signed [15:0] cfg_mismatch = -16'sd1;
  logic [15:0] cfg_gap_o = 16'd3;
  logic [15:0] cfg_gap_e = 16'd1;
  logic cfg_local = 1'b1;
  logic q_load = 1'b0;
  logic [2:0] q_base_in = '0;
  logic signed [15:0] init_h = '0;
  logic signed [15:0] init_diag = '0;
  logic [3:0] out_ptr;
  logic signed [15:0] max_h;
  logic [11:0] max_col;

  int n_cmp = 0;
  int n_err = 0;
  vec_t vt[13];

  affine_pe_stream_if #(.SCORE_W(16), .BASE_W(3)) up_if ();
  affine_pe_stream_if #(.SCORE_W(16), .BASE_W(3)) dn_if ();

  affine_pe_stream #(.SCORE_W(16), .BASE_W(3), .COL_W(12)) dut (
    .clk(clk), .rst(rst),
    .cfg_match(cfg_match), .cfg_mismatch(cfg_mismatch),
    .cfg_gap_o(cfg_gap_o), .cfg_gap_e(cfg_gap_e), .cfg_local(cfg_local),
    .q_load(q_load), .q_base_in(q_base_in), .init_h(init_h), .init_diag(init_diag),
    .in_s(up_if.slave), .out_s(dn_if.master),
    .out_ptr(out_ptr), .max_h(max_h), .max_col(max_col)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic loc, input logic ql, input int ih, input int id,
                              input logic v, input logic [2:0] r, input int h, input int f,
                              input logic ev, input int eh, input int ef, input int ep);
    vec_t t;
    t.loc = loc; t.ql = ql; t.qb = 3'd0; t.ih = 16'(ih); t.id = 16'(id);
    t.v = v; t.r = r; t.h = 16'(h); t.f = 16'(f);
    t.ev = ev; t.eh = 16'(eh); t.ef = 16'(ef); t.ep = 4'(ep);
    return t;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    cfg_local   = t.loc;
    q_load      = t.ql;
    q_base_in   = t.qb;
    init_h      = t.ih;
    init_diag   = t.id;
    up_if.valid = t.v;
    up_if.r     = t.r;
    up_if.h     = t.h;
    up_if.f     = t.f;
  endtask

  task automatic chk_max(input string nm, input int eh, input int ec);
`ifdef PE_MAX_TRACK_EN
    chk({nm, "_max_h"}, max_h, eh);
    chk({nm, "_max_col"}, max_col, ec);
`else
    chk({nm, "_max_h"}, max_h, 0);
    chk({nm, "_max_col"}, max_col, 0);
`endif
  endtask

  initial begin
    //          loc ql  ih   id     v  r  h       f    ev  eh     ef     ep
    vt[0]  = mk(1, 1,  0,   0,     0, 0, 0,      NI,  0,  0,     0,     0);
    vt[1]  = mk(1, 0,  0,   0,     1, 0, 0,      NI,  1,  2,     -3,    3);
    vt[2]  = mk(1, 0,  0,   0,     1, 1, 0,      NI,  1,  0,     -3,    0);
    vt[3]  = mk(1, 0,  0,   0,     1, 0, 2,      NI,  1,  2,     -1,    7);
    vt[4]  = mk(1, 0,  0,   0,     0, 0, 0,      NI,  0,  0,     0,     0);
    vt[5]  = mk(1, 0,  0,   0,     1, 0, 2,      NI,  1,  4,     -1,    3);
    vt[6]  = mk(1, 0,  0,   0,     1, 0, 0,      NI,  1,  4,     -3,    3);
    vt[7]  = mk(0, 1,  -3,  0,     1, 0, 5,      NI,  0,  0,     0,     0);
    vt[8]  = mk(0, 0,  0,   0,     1, 1, 0,      NI,  1,  -1,    -3,    3);
    vt[9]  = mk(0, 1,  0,   32767, 0, 0, 0,      NI,  0,  0,     0,     0);
    vt[10] = mk(0, 0,  0,   0,     1, 0, 32767,  NI,  1,  32767, 32764, 3);
    vt[11] = mk(0, 0,  0,   0,     1, 0, -32768, NI,  1,  32767, -32768, 3);
    vt[12] = mk(0, 0,  0,   0,     1, 1, 0,      100, 1,  32764, 99,    9);

    up_if.valid = 1'b0; up_if.r = '0; up_if.h = '0; up_if.f = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", dn_if.valid, 0);
    chk("rst_h", dn_if.h, 0);
    chk("rst_f", dn_if.f, 0);
    chk("rst_ptr", out_ptr, 0);
    chk_max("rst", 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vt[i]);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), dn_if.valid, vt[i].ev);
      if (vt[i].ev) begin
        chk($sformatf("v%0d_h", i), dn_if.h, vt[i].eh);
        chk($sformatf("v%0d_f", i), dn_if.f, vt[i].ef);
        chk($sformatf("v%0d_ptr", i), out_ptr, vt[i].ep);
        chk($sformatf("v%0d_r", i), dn_if.r, vt[i].r);
      end
      if (i == 6) chk_max("row1", 4, 4);
      if (i == 7) chk_max("reload", 0, 0);
    end

    // Beat then asynchronous reset between edges.
    drive(mk(1, 0, 0, 0, 1, 0, 0, NI, 1, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_valid", dn_if.valid, 1);
    up_if.valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", dn_if.valid, 0);
    chk("async_rst_h", dn_if.h, 0);
    chk("async_rst_f", dn_if.f, 0);
    chk("async_rst_ptr", out_ptr, 0);
    @(negedge clk);
    rst = 1'b0;

    // First beat after reset without q_load runs from the reset state.
    drive(mk(1, 0, 0, 0, 1, 0, 0, NI, 1, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_valid", dn_if.valid, 1);
    chk("post_rst_h", dn_if.h, 2);
    chk("post_rst_f", dn_if.f, -3);
    chk("post_rst_ptr", out_ptr, 3);
    chk_max("post_rst", 2, 1);
    up_if.valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("idle_valid", dn_if.valid, 0);
    chk("idle_hold_h", dn_if.h, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
